// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, W x W -> 2W, unsigned or two's-complement.
// Product ends up in {Aval, Bval}; Xval carries the sign/carry extension of Aval.
module seq_multiplier_n #(
    parameter int W = 8,
    localparam int CW = (W > 1) ? $clog2(W) : 1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Clear,
    input  logic         LoadB,
    input  logic         Run,
    input  logic         Signed_Mode,
    input  logic [W-1:0] Din,
    output logic [W-1:0] Aval,
    output logic [W-1:0] Bval,
    output logic         Xval,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, b_q, s_q;
    logic          x_q, mode_q, run_q;
    logic [CW-1:0] cnt_q;
    logic          start, last;

    assign start = Run & ~run_q;
    assign last  = (cnt_q == CW'(W - 1));

    // One partial-product step; the final signed step subtracts the multiplicand
    // because the top multiplier bit carries negative weight.
    function automatic logic [W:0] add_step(input logic [W-1:0] acc,
                                            input logic [W-1:0] mcand,
                                            input logic         sgn,
                                            input logic         sub);
        logic signed [W:0] ea, es;
        ea = sgn ? $signed({acc[W-1], acc}) : $signed({1'b0, acc});
        es = sgn ? $signed({mcand[W-1], mcand}) : $signed({1'b0, mcand});
        return sub ? (ea - es) : (ea + es);
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = ADD;
            ADD: begin
                Busy    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                Busy    = 1'b1;
                state_d = last ? DONE : ADD;
            end
            DONE: begin
                Done = 1'b1;
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (Clear) state_d = IDLE;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            x_q    <= 1'b0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            run_q <= Run;
            if (Clear) begin
                a_q    <= '0;
                b_q    <= '0;
                s_q    <= '0;
                x_q    <= 1'b0;
                cnt_q  <= '0;
                mode_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            s_q    <= Din;
                            mode_q <= Signed_Mode;
                            a_q    <= '0;
                            x_q    <= 1'b0;
                            cnt_q  <= '0;
                        end else if (LoadB) begin
                            b_q <= Din;
                        end
                    end
                    ADD: begin
                        if (b_q[0]) {x_q, a_q} <= add_step(a_q, s_q, mode_q, mode_q & last);
                    end
                    SHIFT: begin
                        x_q <= mode_q ? x_q : 1'b0;
                        a_q <= {x_q, a_q[W-1:1]};
                        b_q <= {a_q[0], b_q[W-1:1]};
                        if (!last) cnt_q <= cnt_q + 1'b1;
                    end
                    DONE: begin
                        if (LoadB) b_q <= Din;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign Xval = x_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed bench for seq_multiplier_n: W=8 directed vectors plus W=16 and W=3
// instances sharing the control lines, checked against an integer product model.
module tb_seq_multiplier_n;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_n, clear, loadb, run, smode;
    logic [7:0]  din8,  a8,  b8;
    logic [15:0] din16, a16, b16;
    logic [2:0]  din3,  a3,  b3;
    logic x8, busy8, done8, x16, busy16, done16, x3, busy3, done3;

    int tests = 0;
    int fails = 0;

    seq_multiplier_n #(.W(8)) dut8 (
        .Clk(Clk), .Reset_n(rst_n), .Clear(clear), .LoadB(loadb), .Run(run),
        .Signed_Mode(smode), .Din(din8), .Aval(a8), .Bval(b8), .Xval(x8),
        .Busy(busy8), .Done(done8));

    seq_multiplier_n #(.W(16)) dut16 (
        .Clk(Clk), .Reset_n(rst_n), .Clear(clear), .LoadB(loadb), .Run(run),
        .Signed_Mode(smode), .Din(din16), .Aval(a16), .Bval(b16), .Xval(x16),
        .Busy(busy16), .Done(done16));

    seq_multiplier_n #(.W(3)) dut3 (
        .Clk(Clk), .Reset_n(rst_n), .Clear(clear), .LoadB(loadb), .Run(run),
        .Signed_Mode(smode), .Din(din3), .Aval(a3), .Bval(b3), .Xval(x3),
        .Busy(busy3), .Done(done3));

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference product of two w-bit operands.
    function automatic longint prod(input longint m, input longint c, input int w, input logic sg);
        longint mm, cc;
        mm = m;
        cc = c;
        if (sg && mm[w-1]) mm = mm - (longint'(1) << w);
        if (sg && cc[w-1]) cc = cc - (longint'(1) << w);
        return mm * cc;
    endfunction

    // Load multiplier, pulse Run with the multiplicand, collect each instance's result at Done.
    task automatic run_all(input logic [7:0] m8, input logic [7:0] c8,
                           input logic [15:0] m16, input logic [15:0] c16,
                           input logic [2:0] m3, input logic [2:0] c3, input logic sg,
                           output logic [16:0] r8, output logic [32:0] r16, output logic [6:0] r3,
                           output int bc8, output int bc16, output int bc3, output logic ok);
        logic s8, s16, s3;
        loadb = 1'b1; din8 = m8; din16 = m16; din3 = m3;
        tick();
        loadb = 1'b0; din8 = c8; din16 = c16; din3 = c3; smode = sg; run = 1'b1;
        tick();
        run = 1'b0;
        bc8 = 0; bc16 = 0; bc3 = 0; s8 = 0; s16 = 0; s3 = 0;
        r8 = '0; r16 = '0; r3 = '0;
        for (int i = 0; i < 200; i++) begin
            if (done8 && !s8)   begin s8 = 1;  r8 = {x8, a8, b8};    end
            if (done16 && !s16) begin s16 = 1; r16 = {x16, a16, b16}; end
            if (done3 && !s3)   begin s3 = 1;  r3 = {x3, a3, b3};    end
            if (busy8 && !s8)   bc8++;
            if (busy16 && !s16) bc16++;
            if (busy3 && !s3)   bc3++;
            if (s8 && s16 && s3) break;
            tick();
        end
        ok = s8 && s16 && s3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; loadb = 1'b0; run = 1'b0; smode = 1'b0;
        din8 = '0; din16 = '0; din3 = '0;
        #3;
        tests++;
        if ({x8, a8, b8, busy8, done8} !== 19'h0) begin
            fails++; $display("FAIL reset_w8: got %h want 0", {x8, a8, b8, busy8, done8});
        end
        tests++;
        if ({x16, a16, b16, busy16, done16} !== 35'h0) begin
            fails++; $display("FAIL reset_w16: got %h want 0", {x16, a16, b16, busy16, done16});
        end
        tests++;
        if ({x3, a3, b3, busy3, done3} !== 9'h0) begin
            fails++; $display("FAIL reset_w3: got %h want 0", {x3, a3, b3, busy3, done3});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic(input logic sg, input logic [16:0] exp);
        logic [16:0] r8; logic [32:0] r16; logic [6:0] r3;
        int bc8, bc16, bc3; logic ok;
        run_all(8'hFD, 8'h07, 16'h0, 16'h0, 3'h0, 3'h0, sg, r8, r16, r3, bc8, bc16, bc3, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_timeout: done not seen (sg=%0d)", sg); end
        tests++;
        if (bc8 !== 16) begin fails++; $display("FAIL basic_busy_len: got %0d want 16", bc8); end
        tests++;
        if (r8 !== exp) begin fails++; $display("FAIL basic_result sg=%0d: got %h want %h", sg, r8, exp); end
    endtask

    task automatic test_boundaries();
        logic [7:0] bm[6], cm[6]; logic sgv[6]; logic [16:0] ex[6];
        logic [16:0] r8; logic [32:0] r16; logic [6:0] r3;
        int bc8, bc16, bc3; logic ok;
        bm  = '{8'h80, 8'hFF, 8'h80, 8'h00, 8'h5A, 8'hFF};
        cm  = '{8'h80, 8'hFF, 8'h7F, 8'h5A, 8'h00, 8'hFF};
        sgv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ex  = '{17'h0_4000, 17'h0_FE01, 17'h1_C080, 17'h0_0000, 17'h0_0000, 17'h0_0001};
        for (int k = 0; k < 6; k++) begin
            run_all(bm[k], cm[k], 16'h0, 16'h0, 3'h0, 3'h0, sgv[k], r8, r16, r3, bc8, bc16, bc3, ok);
            tests++;
            if (!ok || r8 !== ex[k]) begin
                fails++;
                $display("FAIL boundary_%0d: got %h (done=%0d) want %h", k, r8, ok, ex[k]);
            end
        end
    endtask

    task automatic test_run_held();
        int nb, nd; logic pd;
        loadb = 1'b1; din8 = 8'h03; tick();
        loadb = 1'b0; din8 = 8'h05; smode = 1'b0; run = 1'b1;
        nb = 0; nd = 0; pd = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy8) nb++;
            if (done8 && !pd) nd++;
            pd = done8;
        end
        tests++;
        if (nb !== 16 || nd !== 1) begin
            fails++; $display("FAIL run_held_once: busy=%0d dones=%0d want 16 and 1", nb, nd);
        end
        tests++;
        if ({done8, x8, a8, b8} !== 18'h2_000F) begin
            fails++; $display("FAIL run_held_result: got %h want 2000f", {done8, x8, a8, b8});
        end
        run = 1'b0;
        tick();
        tests++;
        if (done8 !== 1'b0) begin fails++; $display("FAIL run_low_idle: done=%0d want 0", done8); end
        tick();
    endtask

    task automatic test_repulse_toggle();
        int nb, starts; logic seen; logic [16:0] r;
        loadb = 1'b1; din8 = 8'hFD; tick();
        loadb = 1'b0; din8 = 8'h07; smode = 1'b1; run = 1'b1; tick();
        run = 1'b0;
        nb = 0; seen = 1'b0; r = '0;
        for (int i = 0; i < 100; i++) begin
            if (i == 2) run = 1'b1;
            if (i == 3) begin din8 = 8'h55; smode = 1'b0; end
            if (i == 4) run = 1'b0;
            if (done8) begin seen = 1'b1; r = {x8, a8, b8}; break; end
            if (busy8) nb++;
            tick();
        end
        tests++;
        if (!seen || nb !== 16 || r !== 17'h1_FFEB) begin
            fails++; $display("FAIL repulse_result: got %h busy=%0d done=%0d want 1ffeb 16 1", r, nb, seen);
        end
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy8) starts++;
        end
        tests++;
        if (starts !== 0) begin fails++; $display("FAIL repulse_no_restart: busy cycles %0d want 0", starts); end
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_clear();
        int nd;
        loadb = 1'b1; din8 = 8'hFD; tick();
        loadb = 1'b0; din8 = 8'h07; smode = 1'b1; run = 1'b1; tick();
        run = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        clear = 1'b1; tick();
        clear = 1'b0;
        tests++;
        if ({x8, a8, b8, busy8, done8} !== 19'h0) begin
            fails++; $display("FAIL clear_zero: got %h want 0", {x8, a8, b8, busy8, done8});
        end
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done8 || busy8) nd++;
        end
        tests++;
        if (nd !== 0) begin fails++; $display("FAIL clear_stays_idle: active cycles %0d want 0", nd); end
    endtask

    task automatic test_async_reset();
        logic [16:0] r8; logic [32:0] r16; logic [6:0] r3;
        int bc8, bc16, bc3; logic ok;
        loadb = 1'b1; din8 = 8'hFD; din16 = 16'h1234; tick();
        loadb = 1'b0; din8 = 8'h07; din16 = 16'h0F0F; smode = 1'b1; run = 1'b1; tick();
        run = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({x8, a8, b8, busy8, done8} !== 19'h0 || {x16, a16, b16, busy16} !== 34'h0) begin
            fails++; $display("FAIL async_reset: w8 %h w16 %h want 0", {x8, a8, b8, busy8, done8}, {x16, a16, b16, busy16});
        end
        #1 rst_n = 1'b1;
        tick();
        run_all(8'h0C, 8'h0D, 16'h0, 16'h0, 3'h0, 3'h0, 1'b0, r8, r16, r3, bc8, bc16, bc3, ok);
        tests++;
        if (!ok || r8 !== 17'h0_009C) begin
            fails++; $display("FAIL reset_recovery: got %h (done=%0d) want 0009c", r8, ok);
        end
    endtask

    task automatic test_widths();
        logic [16:0] r8; logic [32:0] r16; logic [6:0] r3;
        logic [16:0] e8; logic [32:0] e16; logic [6:0] e3;
        logic [7:0] m8, c8; logic [15:0] m16, c16; logic [2:0] m3, c3;
        int bc8, bc16, bc3; logic ok, sg; longint p;
        for (int k = 0; k < 8; k++) begin
            sg = k[0];
            if (k < 2) begin
                m8 = 8'h80; c8 = 8'h81; m16 = 16'h8000; c16 = 16'h8000; m3 = 3'h4; c3 = 3'h4;
            end else begin
                m8 = 8'($urandom); c8 = 8'($urandom); m16 = 16'($urandom); c16 = 16'($urandom);
                m3 = 3'($urandom); c3 = 3'($urandom);
            end
            run_all(m8, c8, m16, c16, m3, c3, sg, r8, r16, r3, bc8, bc16, bc3, ok);
            p = prod(longint'(m8), longint'(c8), 8, sg);    e8  = {sg && p < 0, p[15:0]};
            p = prod(longint'(m16), longint'(c16), 16, sg); e16 = {sg && p < 0, p[31:0]};
            p = prod(longint'(m3), longint'(c3), 3, sg);    e3  = {sg && p < 0, p[5:0]};
            tests++;
            if (!ok || r16 !== e16 || bc16 !== 32) begin
                fails++; $display("FAIL w16_%0d: %h*%h sg=%0d got %h busy=%0d want %h 32", k, m16, c16, sg, r16, bc16, e16);
            end
            tests++;
            if (!ok || r3 !== e3 || bc3 !== 6) begin
                fails++; $display("FAIL w3_%0d: %h*%h sg=%0d got %h busy=%0d want %h 6", k, m3, c3, sg, r3, bc3, e3);
            end
            tests++;
            if (!ok || r8 !== e8) begin
                fails++; $display("FAIL w8_model_%0d: %h*%h sg=%0d got %h want %h", k, m8, c8, sg, r8, e8);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic(1'b1, 17'h1_FFEB);
        test_basic(1'b0, 17'h0_06EB);
        test_boundaries();
        test_run_held();
        test_repulse_toggle();
        test_clear();
        test_async_reset();
        test_widths();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
